// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32 control pipeline: opcodes, encodings and
// the per-stage control bundles carried down the D->E->M->W registers.
package ctrl_pkg;

    // Main opcode field values (instruction bits [6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_PASSB = 2'b11
    } aluop_e;

    // Immediate format select for the immediate generator
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_e;

    // Writeback result select
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultsrc_e;

    // Full control bundle as it leaves Decode and sits in E
    typedef struct packed {
        logic       regWrite;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       memWrite;
        resultsrc_e resultSrc;
        logic       branch;
        aluop_e     aluOp;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_t;

    // Subset of the bundle still needed once the ALU has been used
    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        resultsrc_e resultSrc;
        logic       illegal;
    } ctrl_m_t;

    // Subset of the bundle needed for register-file writeback
    typedef struct packed {
        logic       regWrite;
        resultsrc_e resultSrc;
        logic       illegal;
    } ctrl_w_t;

    localparam ctrl_t   CTRL_BUBBLE   = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle of the control pipeline's opcode input, hazard controls and the
// per-stage control outputs. The core side drives through master, the
// control pipeline itself connects through slave.
interface ctrl_pipe_if #(
    parameter int CNT_W = 8
);
    logic [6:0]       op_d;
    logic             stall_e;
    logic             flush_e;

    logic [2:0]       immsrc_d;
    logic             illegal_d;

    logic             regwrite_e;
    logic             memwrite_e;
    logic             branch_e;
    logic             jump_e;
    logic             jalr_e;
    logic             alusrca_e;
    logic             alusrcb_e;
    logic             illegal_e;
    logic [1:0]       resultsrc_e;
    logic [1:0]       aluop_e;

    logic             regwrite_m;
    logic             memwrite_m;
    logic [1:0]       resultsrc_m;

    logic             regwrite_w;
    logic             illegal_w;
    logic [1:0]       resultsrc_w;

    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output op_d, stall_e, flush_e,
        input  immsrc_d, illegal_d,
        input  regwrite_e, memwrite_e, branch_e, jump_e, jalr_e,
        input  alusrca_e, alusrcb_e, illegal_e, resultsrc_e, aluop_e,
        input  regwrite_m, memwrite_m, resultsrc_m,
        input  regwrite_w, illegal_w, resultsrc_w,
        input  illegal_cnt
    );

    modport slave (
        input  op_d, stall_e, flush_e,
        output immsrc_d, illegal_d,
        output regwrite_e, memwrite_e, branch_e, jump_e, jalr_e,
        output alusrca_e, alusrcb_e, illegal_e, resultsrc_e, aluop_e,
        output regwrite_m, memwrite_m, resultsrc_m,
        output regwrite_w, illegal_w, resultsrc_w,
        output illegal_cnt
    );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational main-opcode decoder for the Decode stage.
// Unknown opcodes, and the extended opcodes when EXT_OPS is 0, produce an
// all-zero bundle with only the illegal flag raised.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [6:0] op_i,
    output ctrl_t      ctrl_o,
    output immsrc_e    immSrc_o
);

    // Map the opcode onto its control bundle, defaulting everything to zero
    always_comb begin
        ctrl_o   = CTRL_BUBBLE;
        immSrc_o = IMM_I;
        case (op_i)
            OP_LOAD: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluSrcB   = 1'b1;
                ctrl_o.resultSrc = RES_MEM;
            end
            OP_STORE: begin
                immSrc_o         = IMM_S;
                ctrl_o.aluSrcB   = 1'b1;
                ctrl_o.memWrite  = 1'b1;
            end
            OP_RTYPE: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluOp     = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                immSrc_o         = IMM_B;
                ctrl_o.branch    = 1'b1;
                ctrl_o.aluOp     = ALUOP_SUB;
            end
            OP_IALU: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluSrcB   = 1'b1;
                ctrl_o.aluOp     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                immSrc_o         = IMM_J;
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.resultSrc = RES_PC4;
                ctrl_o.jump      = 1'b1;
            end
            OP_JALR: begin
                if (EXT_OPS != 0) begin
                    ctrl_o.regWrite  = 1'b1;
                    ctrl_o.aluSrcB   = 1'b1;
                    ctrl_o.resultSrc = RES_PC4;
                    ctrl_o.jump      = 1'b1;
                    ctrl_o.jalr      = 1'b1;
                end else begin
                    ctrl_o.illegal   = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_OPS != 0) begin
                    immSrc_o         = IMM_U;
                    ctrl_o.regWrite  = 1'b1;
                    ctrl_o.aluSrcB   = 1'b1;
                    ctrl_o.aluOp     = ALUOP_PASSB;
                end else begin
                    ctrl_o.illegal   = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (EXT_OPS != 0) begin
                    immSrc_o         = IMM_U;
                    ctrl_o.regWrite  = 1'b1;
                    ctrl_o.aluSrcA   = 1'b1;
                    ctrl_o.aluSrcB   = 1'b1;
                end else begin
                    ctrl_o.illegal   = 1'b1;
                end
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control unit for the pipelined RV32 core: decodes the opcode in D and
// carries the control bundle through the E, M and W registers, honouring
// the hazard unit's stall/flush, and counts illegal instructions reaching W.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    ctrl_pipe_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_t            decodeCtrl;
    immsrc_e          decodeImm;

    ctrl_t            ctrlE_d, ctrlE_q;
    ctrl_m_t          ctrlM_d, ctrlM_q;
    ctrl_w_t          ctrlW_d, ctrlW_q;
    logic [CNT_W-1:0] illegalCnt_d, illegalCnt_q;

    ctrl_decode #(
        .EXT_OPS (EXT_OPS)
    ) uDecode (
        .op_i     (bus.op_d),
        .ctrl_o   (decodeCtrl),
        .immSrc_o (decodeImm)
    );

    // Next-state for every stage: flush beats stall in E, a stalled E sends
    // a bubble into M, W always follows M, counter saturates instead of wrapping
    always_comb begin
        ctrlE_d = decodeCtrl;
        if (bus.flush_e) begin
            ctrlE_d = CTRL_BUBBLE;
        end else if (bus.stall_e) begin
            ctrlE_d = ctrlE_q;
        end

        ctrlM_d = CTRL_M_BUBBLE;
        if (!bus.stall_e) begin
            ctrlM_d.regWrite  = ctrlE_q.regWrite;
            ctrlM_d.memWrite  = ctrlE_q.memWrite;
            ctrlM_d.resultSrc = ctrlE_q.resultSrc;
            ctrlM_d.illegal   = ctrlE_q.illegal;
        end

        ctrlW_d.regWrite  = ctrlM_q.regWrite;
        ctrlW_d.resultSrc = ctrlM_q.resultSrc;
        ctrlW_d.illegal   = ctrlM_q.illegal;

        illegalCnt_d = illegalCnt_q;
        if (ctrlM_q.illegal && (illegalCnt_q != CNT_MAX)) begin
            illegalCnt_d = illegalCnt_q + CNT_ONE;
        end
    end

    // Pipeline registers and counter; synchronous reset clears every stage at once
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlE_q      <= CTRL_BUBBLE;
            ctrlM_q      <= CTRL_M_BUBBLE;
            ctrlW_q      <= CTRL_W_BUBBLE;
            illegalCnt_q <= '0;
        end else begin
            ctrlE_q      <= ctrlE_d;
            ctrlM_q      <= ctrlM_d;
            ctrlW_q      <= ctrlW_d;
            illegalCnt_q <= illegalCnt_d;
        end
    end

    assign bus.immsrc_d    = decodeImm;
    assign bus.illegal_d   = decodeCtrl.illegal;

    assign bus.regwrite_e  = ctrlE_q.regWrite;
    assign bus.memwrite_e  = ctrlE_q.memWrite;
    assign bus.branch_e    = ctrlE_q.branch;
    assign bus.jump_e      = ctrlE_q.jump;
    assign bus.jalr_e      = ctrlE_q.jalr;
    assign bus.alusrca_e   = ctrlE_q.aluSrcA;
    assign bus.alusrcb_e   = ctrlE_q.aluSrcB;
    assign bus.illegal_e   = ctrlE_q.illegal;
    assign bus.resultsrc_e = ctrlE_q.resultSrc;
    assign bus.aluop_e     = ctrlE_q.aluOp;

    assign bus.regwrite_m  = ctrlM_q.regWrite;
    assign bus.memwrite_m  = ctrlM_q.memWrite;
    assign bus.resultsrc_m = ctrlM_q.resultSrc;

    assign bus.regwrite_w  = ctrlW_q.regWrite;
    assign bus.illegal_w   = ctrlW_q.illegal;
    assign bus.resultsrc_w = ctrlW_q.resultSrc;

    assign bus.illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: two instances side by side (extended opcodes with
// an 8-bit counter, base opcodes with a 2-bit counter) share one stimulus
// stream and are compared against a table-driven reference model.
module tb_ctrl_pipe;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    ctrl_pipe_if #(.CNT_W(8)) busA ();
    ctrl_pipe_if #(.CNT_W(2)) busB ();

    ctrl_pipe #(.EXT_OPS(1), .CNT_W(8)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    ctrl_pipe #(.EXT_OPS(0), .CNT_W(2)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never finishes
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model state; vector layout {illegal, RegWrite, ImmSrc[2:0],
    // ALUSrcA, ALUSrcB, MemWrite, ResultSrc[1:0], Branch, ALUOp[1:0], Jump, Jalr}
    logic [14:0] mE [2];
    logic [14:0] mM [2];
    logic [14:0] mW [2];
    int          mCnt [2];
    int          cntMax [2] = '{255, 3};

    // Opcode table straight from the decode rules, field order as listed above
    function automatic logic [14:0] refDecode(input logic [6:0] op, input bit ext);
        logic [13:0] c;
        logic        ill;
        c   = '0;
        ill = 1'b0;
        case (op)
            7'b0000011: c = 14'b1_000_0_1_0_01_0_00_0_0;
            7'b0100011: c = 14'b0_001_0_1_1_00_0_00_0_0;
            7'b0110011: c = 14'b1_000_0_0_0_00_0_10_0_0;
            7'b1100011: c = 14'b0_010_0_0_0_00_1_01_0_0;
            7'b0010011: c = 14'b1_000_0_1_0_00_0_10_0_0;
            7'b1101111: c = 14'b1_011_0_0_0_10_0_00_1_0;
            7'b1100111: if (ext) c = 14'b1_000_0_1_0_10_0_00_1_1; else ill = 1'b1;
            7'b0110111: if (ext) c = 14'b1_100_0_1_0_00_0_11_0_0; else ill = 1'b1;
            7'b0010111: if (ext) c = 14'b1_100_1_1_0_00_0_00_0_0; else ill = 1'b1;
            default:    ill = 1'b1;
        endcase
        if (ill) c = '0;
        return {ill, c};
    endfunction

    // E-stage view: {illegal, RegWrite, ALUSrcA, ALUSrcB, MemWrite, ResultSrc, Branch, ALUOp, Jump, Jalr}
    function automatic logic [11:0] viewE(input logic [14:0] v);
        return {v[14], v[13], v[9:0]};
    endfunction

    // M-stage view: {illegal, RegWrite, MemWrite, ResultSrc}
    function automatic logic [4:0] viewM(input logic [14:0] v);
        return {v[14], v[13], v[7], v[6:5]};
    endfunction

    // W-stage view: {illegal, RegWrite, ResultSrc}
    function automatic logic [3:0] viewW(input logic [14:0] v);
        return {v[14], v[13], v[6:5]};
    endfunction

    // One comparison: counts it, and on a miss counts the failure and reports it
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check decode, clock, advance model, check stages
    task automatic applyStimulus(input logic [6:0] op, input logic stall,
                                 input logic flush, input logic rst);
        logic [14:0] dec;
        logic [14:0] nE, nM, nW;
        int          nC;

        reset        = rst;
        busA.op_d    = op;
        busA.stall_e = stall;
        busA.flush_e = flush;
        busB.op_d    = op;
        busB.stall_e = stall;
        busB.flush_e = flush;
        #1;

        dec = refDecode(op, 1'b1);
        checkOutput("A.immsrc_d",  32'(busA.immsrc_d),  32'(dec[12:10]));
        checkOutput("A.illegal_d", 32'(busA.illegal_d), 32'(dec[14]));
        dec = refDecode(op, 1'b0);
        checkOutput("B.immsrc_d",  32'(busB.immsrc_d),  32'(dec[12:10]));
        checkOutput("B.illegal_d", 32'(busB.illegal_d), 32'(dec[14]));

        for (int k = 0; k < 2; k++) begin
            dec = refDecode(op, k == 0);
            if (rst) begin
                nE = '0; nM = '0; nW = '0; nC = 0;
            end else begin
                nW = mM[k];
                nC = (mM[k][14] && mCnt[k] < cntMax[k]) ? mCnt[k] + 1 : mCnt[k];
                nM = stall ? 15'd0 : mE[k];
                nE = flush ? 15'd0 : (stall ? mE[k] : dec);
            end
            mE[k] = nE; mM[k] = nM; mW[k] = nW; mCnt[k] = nC;
        end

        @(posedge clk);
        #1;

        checkOutput("A.E", 32'({busA.illegal_e, busA.regwrite_e, busA.alusrca_e, busA.alusrcb_e,
                                busA.memwrite_e, busA.resultsrc_e, busA.branch_e, busA.aluop_e,
                                busA.jump_e, busA.jalr_e}), 32'(viewE(mE[0])));
        checkOutput("A.M", 32'({1'b0, busA.regwrite_m, busA.memwrite_m, busA.resultsrc_m}),
                    32'({1'b0, viewM(mM[0])} & 6'b01_1111 & ~6'b01_0000) | 32'(viewM(mM[0]) & 5'b01111));
        checkOutput("A.W", 32'({busA.illegal_w, busA.regwrite_w, busA.resultsrc_w}), 32'(viewW(mW[0])));
        checkOutput("A.cnt", 32'(busA.illegal_cnt), 32'(mCnt[0]));

        checkOutput("B.E", 32'({busB.illegal_e, busB.regwrite_e, busB.alusrca_e, busB.alusrcb_e,
                                busB.memwrite_e, busB.resultsrc_e, busB.branch_e, busB.aluop_e,
                                busB.jump_e, busB.jalr_e}), 32'(viewE(mE[1])));
        checkOutput("B.M", 32'({busB.regwrite_m, busB.memwrite_m, busB.resultsrc_m}),
                    32'(viewM(mM[1]) & 5'b01111));
        checkOutput("B.W", 32'({busB.illegal_w, busB.regwrite_w, busB.resultsrc_w}), 32'(viewW(mW[1])));
        checkOutput("B.cnt", 32'(busB.illegal_cnt), 32'(mCnt[1]));
    endtask

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RT    = 7'b0110011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] IALU  = 7'b0010011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BAD   = 7'b0000000;

    // Directed sequence, then a randomized run
    initial begin
        logic [6:0] opTab [10];
        logic [6:0] op;
        opTab = '{LW, SW, RT, BEQ, IALU, JAL, JALR, LUI, AUIPC, BAD};
        for (int k = 0; k < 2; k++) begin
            mE[k] = '0; mM[k] = '0; mW[k] = '0; mCnt[k] = 0;
        end

        // Reset for two cycles, then a load flows down the pipe
        applyStimulus(LW, 1'b0, 1'b0, 1'b1);
        applyStimulus(LW, 1'b0, 1'b0, 1'b1);
        checkOutput("A.reset_cnt", 32'(busA.illegal_cnt), 32'd0);
        applyStimulus(LW, 1'b0, 1'b0, 1'b0);
        checkOutput("A.lw_regwrite_e", 32'(busA.regwrite_e), 32'd1);
        checkOutput("A.lw_resultsrc_e", 32'(busA.resultsrc_e), 32'd1);
        applyStimulus(RT, 1'b0, 1'b0, 1'b0);
        applyStimulus(RT, 1'b0, 1'b0, 1'b0);
        checkOutput("A.lw_resultsrc_w", 32'(busA.resultsrc_w), 32'd1);

        // Store held in E by a two-cycle stall, M gets bubbles meanwhile
        applyStimulus(SW, 1'b0, 1'b0, 1'b0);
        applyStimulus(RT, 1'b1, 1'b0, 1'b0);
        checkOutput("A.stall_memwrite_m", 32'(busA.memwrite_m), 32'd0);
        applyStimulus(RT, 1'b1, 1'b0, 1'b0);
        checkOutput("A.stall_memwrite_e", 32'(busA.memwrite_e), 32'd1);
        applyStimulus(RT, 1'b0, 1'b0, 1'b0);
        checkOutput("A.release_memwrite_m", 32'(busA.memwrite_m), 32'd1);

        // Every opcode class, extended ones legal only on A
        busA.op_d = LUI;
        #1;
        checkOutput("A.lui_immsrc_d", 32'(busA.immsrc_d), 32'd4);
        applyStimulus(LUI,   1'b0, 1'b0, 1'b0);
        checkOutput("A.lui_aluop_e", 32'(busA.aluop_e), 32'd3);
        checkOutput("B.lui_illegal_e", 32'(busB.illegal_e), 32'd1);
        applyStimulus(AUIPC, 1'b0, 1'b0, 1'b0);
        applyStimulus(JALR,  1'b0, 1'b0, 1'b0);
        applyStimulus(BEQ,   1'b0, 1'b0, 1'b0);
        applyStimulus(IALU,  1'b0, 1'b0, 1'b0);
        applyStimulus(JAL,   1'b0, 1'b0, 1'b0);

        // Flush and stall together: flush wins in E, M still bubbles
        applyStimulus(JAL, 1'b1, 1'b1, 1'b0);
        checkOutput("A.flushstall_jump_e", 32'(busA.jump_e), 32'd0);
        applyStimulus(JAL, 1'b0, 1'b1, 1'b0);
        applyStimulus(RT,  1'b0, 1'b0, 1'b0);

        // Clean reset, then five illegal opcodes to saturate B's 2-bit counter
        applyStimulus(RT, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(BAD, 1'b0, 1'b0, 1'b0);
        applyStimulus(RT, 1'b0, 1'b0, 1'b0);
        applyStimulus(RT, 1'b0, 1'b0, 1'b0);
        checkOutput("B.cnt_saturated", 32'(busB.illegal_cnt), 32'd3);
        checkOutput("A.cnt_five", 32'(busA.illegal_cnt), 32'd5);

        // Reset mid-stream with jal/sw/lw in E/M/W
        applyStimulus(LW,  1'b0, 1'b0, 1'b0);
        applyStimulus(SW,  1'b0, 1'b0, 1'b0);
        applyStimulus(JAL, 1'b0, 1'b0, 1'b0);
        applyStimulus(JAL, 1'b0, 1'b0, 1'b1);
        checkOutput("A.midreset_regwrite_w", 32'(busA.regwrite_w), 32'd0);

        // Randomized run mixing all opcodes, hazards and occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else                          op = opTab[$urandom_range(0, 9)];
            applyStimulus(op,
                          1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 6) == 0),
                          1'($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
